// File: rtl/tile_pkg.sv
// Shared constants for the tile renderer: mode encodings, raster origin and
// the built-in tile ROM image used when no init file is supplied.
package tile_pkg;

  localparam logic [1:0] MODE_MAP   = 2'b00;
  localparam logic [1:0] MODE_TILE  = 2'b01;
  localparam logic [1:0] MODE_SOLID = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

  localparam int HLEFT_DEF = 144;
  localparam int VTOP_DEF  = 31;

  // Built-in image: per-tile seed byte, scrambled per pixel so offsets are visible.
  function automatic logic [7:0] default_pix(input int t, input int p);
    logic [7:0] seed;
    case (t)
      0:       seed = 8'h3A;
      1:       seed = 8'h47;
      2:       seed = 8'h90;
      3:       seed = 8'hE5;
      4:       seed = 8'h6B;
      5:       seed = 8'h1C;
      6:       seed = 8'hD2;
      7:       seed = 8'h58;
      8:       seed = 8'hA1;
      9:       seed = 8'h0F;
      10:      seed = 8'hC6;
      11:      seed = 8'h7E;
      12:      seed = 8'h29;
      13:      seed = 8'hB4;
      14:      seed = 8'h83;
      default: seed = 8'h5D;
    endcase
    return seed ^ 8'(p * 37);
  endfunction

endpackage

// File: rtl/tile_map_ram.sv
// Tile map storage: one write port, one registered read port; a read that
// collides with a write to the same address returns the previous contents.
module tile_map_ram
  import tile_pkg::*;
#(
  parameter int AW = 13,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/tile_renderer.sv
// Four-stage tile renderer: raster position -> map lookup -> tile line fetch
// -> pixel select, with syncs and active-video delayed to match.
module tile_renderer
  import tile_pkg::*;
#(
  parameter int    TW_LOG2   = 3,
  parameter int    TH_LOG2   = 3,
  parameter int    NT_LOG2   = 4,
  parameter int    RW        = 3,
  parameter int    GW        = 3,
  parameter int    BW        = 2,
  parameter int    BPP       = RW + GW + BW,
  parameter int    MC_LOG2   = 7,
  parameter int    MR_LOG2   = 6,
  parameter int    HLEFT     = HLEFT_DEF,
  parameter int    VTOP      = VTOP_DEF,
  parameter string INIT_FILE = ""
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [9:0]                 hcount,
  input  logic [9:0]                 vcount,
  input  logic                       bright,
  input  logic                       hsync_in,
  input  logic                       vsync_in,
  input  logic [1:0]                 mode,
  input  logic [NT_LOG2-1:0]         tsel,
  input  logic [BPP-1:0]             solid,
  input  logic [MC_LOG2+TW_LOG2-1:0] hscroll,
  input  logic [MR_LOG2+TH_LOG2-1:0] vscroll,
  input  logic                       map_we,
  input  logic [MR_LOG2+MC_LOG2-1:0] map_addr,
  input  logic [NT_LOG2-1:0]         map_data,
  output logic [RW-1:0]              R,
  output logic [GW-1:0]              G,
  output logic [BW-1:0]              B,
  output logic                       hsync_out,
  output logic                       vsync_out
);

  localparam int XW = MC_LOG2 + TW_LOG2;
  localparam int YW = MR_LOG2 + TH_LOG2;
  localparam int AW = MR_LOG2 + MC_LOG2;
  localparam int PW = TW_LOG2 + TH_LOG2;
  localparam int LW = (1 << PW) * BPP;
  localparam int NT = 1 << NT_LOG2;

  logic [XW-1:0]      hscroll_l, x;
  logic [YW-1:0]      vscroll_l, y;
  logic [AW-1:0]      addr_p1;
  logic [PW-1:0]      pix_p1, pix_p2, pix_p3;
  logic [1:0]         mode_p1, mode_p2;
  logic [NT_LOG2-1:0] tsel_p1, tsel_p2, map_q, idx;
  logic [BPP-1:0]     solid_p1, solid_p2, solid_p3, px, colour;
  logic               use_solid_p3;
  logic [LW-1:0]      line_p3;
  logic               vld_p1, vld_p2, vld_p3;
  logic               hs_p1, hs_p2, hs_p3, vs_p1, vs_p2, vs_p3;

  logic [LW-1:0] rom [0:NT-1];

  initial begin
    for (int t = 0; t < NT; t++)
      for (int p = 0; p < (1 << PW); p++)
        rom[t][p*BPP +: BPP] = BPP'(default_pix(t, p));
  end

  // Scroll offsets only move at the top-left corner so a frame never tears.
  always_ff @(posedge clk) begin
    if (rst) begin
      hscroll_l <= '0;
      vscroll_l <= '0;
    end else if (hcount == 10'd0 && vcount == 10'd0) begin
      hscroll_l <= hscroll;
      vscroll_l <= vscroll;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {vld_p1, vld_p2, vld_p3} <= '0;
      {hs_p1, hs_p2, hs_p3}    <= '0;
      {vs_p1, vs_p2, vs_p3}    <= '0;
    end else begin
      {vld_p1, vld_p2, vld_p3} <= {bright, vld_p1, vld_p2};
      {hs_p1, hs_p2, hs_p3}    <= {hsync_in, hs_p1, hs_p2};
      {vs_p1, vs_p2, vs_p3}    <= {vsync_in, vs_p1, vs_p2};
    end
  end

  // Stage 1: scrolled map coordinates; wraps modulo the map size by truncation.
  assign x = XW'(32'(hcount) - HLEFT) + hscroll_l;
  assign y = YW'(32'(vcount) - VTOP) + vscroll_l;

  always_ff @(posedge clk) begin
    addr_p1  <= {y[YW-1:TH_LOG2], x[XW-1:TW_LOG2]};
    pix_p1   <= {y[TH_LOG2-1:0], x[TW_LOG2-1:0]};
    mode_p1  <= mode;
    tsel_p1  <= tsel;
    solid_p1 <= solid;
  end

  // Stage 2: tile index from the map RAM, or the directly selected tile.
  tile_map_ram #(.AW(AW), .DW(NT_LOG2)) u_map (
    .clk   (clk),
    .we    (map_we),
    .waddr (map_addr),
    .wdata (map_data),
    .raddr (addr_p1),
    .rdata (map_q)
  );

  always_ff @(posedge clk) begin
    pix_p2   <= pix_p1;
    mode_p2  <= mode_p1;
    tsel_p2  <= tsel_p1;
    solid_p2 <= solid_p1;
  end

  assign idx = (mode_p2 == MODE_TILE) ? tsel_p2 : map_q;

  // Stage 3: whole tile fetched as one wide line.
  always_ff @(posedge clk) begin
    line_p3      <= rom[idx];
    pix_p3       <= pix_p2;
    use_solid_p3 <= mode_p2[1];
    solid_p3     <= solid_p2;
  end

  // Stage 4: pixel select, solid override and active-video blanking.
  assign px     = line_p3[32'(pix_p3)*BPP +: BPP];
  assign colour = use_solid_p3 ? solid_p3 : px;

  always_ff @(posedge clk) begin
    if (rst) begin
      R         <= '0;
      G         <= '0;
      B         <= '0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      hsync_out <= hs_p3;
      vsync_out <= vs_p3;
      if (vld_p3) begin
        R <= colour[RW-1:0];
        G <= colour[RW+GW-1:RW];
        B <= colour[BPP-1:RW+GW];
      end else begin
        R <= '0;
        G <= '0;
        B <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tile_renderer.sv
// Directed bench for tile_renderer: reset, modes, scrolling, blanking, syncs,
// map write collision and mid-line reset flush.
module tb_tile_renderer;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  hcount, vcount;
  logic        bright, hsync_in, vsync_in;
  logic [1:0]  mode;
  logic [3:0]  tsel;
  logic [7:0]  solid;
  logic [9:0]  hscroll;
  logic [8:0]  vscroll;
  logic        map_we;
  logic [12:0] map_addr;
  logic [3:0]  map_data;
  logic [2:0]  R, G;
  logic [1:0]  B;
  logic        hsync_out, vsync_out;
  logic [7:0]  rgb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign rgb = {B, G, R};

  tile_renderer dut (
    .clk       (clk),
    .rst       (rst),
    .hcount    (hcount),
    .vcount    (vcount),
    .bright    (bright),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .mode      (mode),
    .tsel      (tsel),
    .solid     (solid),
    .hscroll   (hscroll),
    .vscroll   (vscroll),
    .map_we    (map_we),
    .map_addr  (map_addr),
    .map_data  (map_data),
    .R         (R),
    .G         (G),
    .B         (B),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out)
  );

  // Expected ROM image, written out independently of the design.
  function automatic logic [7:0] tile_byte(input int t, input int p);
    logic [7:0] seeds [16];
    logic [7:0] mult;
    seeds = '{8'h3A, 8'h47, 8'h90, 8'hE5, 8'h6B, 8'h1C, 8'hD2, 8'h58,
              8'hA1, 8'h0F, 8'hC6, 8'h7E, 8'h29, 8'hB4, 8'h83, 8'h5D};
    mult = 8'((p * 37) % 256);
    return seeds[t] ^ mult;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic map_write(input logic [12:0] a, input logic [3:0] d);
    map_we = 1'b1; map_addr = a; map_data = d;
    tick;
    map_we = 1'b0;
  endtask

  task automatic run_pixel(input logic [9:0] h, input logic [9:0] v, input logic b);
    hcount = h; vcount = v; bright = b;
    repeat (4) tick;
  endtask

  task automatic latch_scroll(input logic [9:0] hs, input logic [8:0] vs);
    hscroll = hs; vscroll = vs; hcount = 10'd0; vcount = 10'd0; bright = 1'b0;
    tick;
    hcount = 10'd500; vcount = 10'd200;
  endtask

  initial begin
    rst = 1'b1; hcount = '0; vcount = '0; bright = 1'b1;
    hsync_in = 1'b1; vsync_in = 1'b1; mode = 2'b10; tsel = '0; solid = 8'hFF;
    hscroll = '0; vscroll = '0; map_we = 1'b0; map_addr = '0; map_data = '0;

    // Map is written while reset is held.
    repeat (2) tick;
    map_write(13'd0, 4'd2);
    map_write(13'd1, 4'd5);
    map_write(13'd127, 4'd9);
    map_write(13'd128, 4'd12);
    check("reset_rgb", rgb, 8'h00);
    check("reset_hsync", hsync_out, 1'b0);
    check("reset_vsync", vsync_out, 1'b0);

    hsync_in = 1'b0; vsync_in = 1'b0; bright = 1'b0;
    rst = 1'b0;
    latch_scroll(10'd0, 9'd0);

    mode = 2'b01; tsel = 4'd3;
    run_pixel(10'd144, 10'd31, 1'b1);
    check("tile3_rgb", rgb, 8'hE5);
    check("tile3_R", R, 3'b101);
    check("tile3_G", G, 3'b100);
    check("tile3_B", B, 2'b11);
    tsel = 4'd7;
    run_pixel(10'd145, 10'd32, 1'b1);
    check("tile7_p9", rgb, tile_byte(7, 9));

    mode = 2'b00;
    run_pixel(10'd152, 10'd31, 1'b1);
    check("map_col1", rgb, 8'h1C);
    run_pixel(10'd151, 10'd31, 1'b1);
    check("map_col0_p7", rgb, tile_byte(2, 7));
    run_pixel(10'd147, 10'd33, 1'b1);
    check("map_p19", rgb, tile_byte(2, 19));
    run_pixel(10'd144, 10'd39, 1'b1);
    check("map_row1", rgb, tile_byte(12, 0));

    mode = 2'b10; solid = 8'hFF;
    run_pixel(10'd144, 10'd31, 1'b0);
    check("solid_blank", rgb, 8'h00);
    run_pixel(10'd144, 10'd31, 1'b1);
    check("solid_ff", rgb, 8'hFF);
    mode = 2'b11; solid = 8'hA6;
    run_pixel(10'd144, 10'd31, 1'b1);
    check("mode11_solid", rgb, 8'hA6);
    mode = 2'b00;
    run_pixel(10'd152, 10'd31, 1'b0);
    check("map_blank", rgb, 8'h00);

    latch_scroll(10'd8, 9'd0);
    run_pixel(10'd144, 10'd31, 1'b1);
    check("hscroll8", rgb, 8'h1C);
    hscroll = 10'd0;
    run_pixel(10'd144, 10'd31, 1'b1);
    check("hscroll_hold", rgb, 8'h1C);
    latch_scroll(10'd1023, 9'd0);
    run_pixel(10'd145, 10'd31, 1'b1);
    check("hscroll_wrap", rgb, tile_byte(2, 0));
    run_pixel(10'd144, 10'd31, 1'b1);
    check("hscroll_col127", rgb, tile_byte(9, 7));
    latch_scroll(10'd0, 9'd8);
    run_pixel(10'd144, 10'd31, 1'b1);
    check("vscroll8", rgb, tile_byte(12, 0));
    latch_scroll(10'd0, 9'd0);

    bright = 1'b0;
    for (int i = 0; i < 6; i++) begin
      hsync_in = (i == 0); vsync_in = (i == 0);
      tick;
      check($sformatf("hsync_d%0d", i + 1), hsync_out, (i == 3));
      check($sformatf("vsync_d%0d", i + 1), vsync_out, (i == 3));
    end

    // Write lands in the cycle stage 2 reads the same entry.
    mode = 2'b00; hcount = 10'd144; vcount = 10'd31; bright = 1'b1;
    tick;
    hcount = 10'd145;
    map_we = 1'b1; map_addr = 13'd0; map_data = 4'd6;
    tick;
    map_we = 1'b0; bright = 1'b0; hcount = 10'd200;
    tick;
    tick;
    check("collide_old", rgb, tile_byte(2, 0));
    tick;
    check("collide_new", rgb, tile_byte(6, 1));

    mode = 2'b10; solid = 8'hFF; bright = 1'b1; hsync_in = 1'b1;
    hcount = 10'd300; vcount = 10'd100;
    repeat (5) tick;
    check("pre_rst_rgb", rgb, 8'hFF);
    check("pre_rst_hsync", hsync_out, 1'b1);
    rst = 1'b1;
    tick;
    check("rst_rgb", rgb, 8'h00);
    check("rst_hsync", hsync_out, 1'b0);
    tick;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      check($sformatf("resume_rgb_%0d", i + 1), rgb, (i == 3) ? 8'hFF : 8'h00);
      check($sformatf("resume_hsync_%0d", i + 1), hsync_out, (i == 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
